mem_lsu: RTL



---
 rtl/mem_lsu.sv | 315 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: openMIPS memory stage with a req/ack load/store unit.
// Optional MEM_ALIGN_CHECK_EN: trap misaligned half/word accesses.
module mem_lsu #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [REG_AW-1:0]   in_waddr,
    input  logic                in_wreg,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic                in_we_hilo,
    input  logic [DATA_W-1:0]   in_wdata_hi,
    input  logic [DATA_W-1:0]   in_wdata_lo,
    input  logic [3:0]          in_memop,
    input  logic [ADDR_W-1:0]   in_maddr,
    input  logic [DATA_W-1:0]   in_sdata,
    output logic                dm_req,
    output logic                dm_we,
    output logic [ADDR_W-1:0]   dm_addr,
    output logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_wdata,
    input  logic                dm_ack,
    input  logic [DATA_W-1:0]   dm_rdata,
    output logic                out_valid,
    output logic                out_wreg,
    output logic [REG_AW-1:0]   out_waddr,
    output logic [DATA_W-1:0]   out_wdata,
    output logic                out_we_hilo,
    output logic [DATA_W-1:0]   out_wdata_hi,
    output logic [DATA_W-1:0]   out_wdata_lo,
`ifdef MEM_ALIGN_CHECK_EN
    output logic                out_align_exc,
`endif
    output logic                stall_req
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int NH    = BE_W / 2;
    localparam int NW    = BE_W / 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic              wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              hilo_q, hilo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              ld_q, ld_d;
    logic [1:0]        sz_q, sz_d;
    logic              sx_q, sx_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] sdat_q, sdat_d;
    logic              exc_q, exc_d;

    logic              ov_q, ov_d;
    logic              owreg_q, owreg_d;
    logic [REG_AW-1:0] owaddr_q, owaddr_d;
    logic [DATA_W-1:0] owdata_q, owdata_d;
    logic              ohilo_q, ohilo_d;
    logic [DATA_W-1:0] ohi_q, ohi_d;
    logic [DATA_W-1:0] olo_q, olo_d;
`ifdef MEM_ALIGN_CHECK_EN
    logic              oexc_q, oexc_d;
`endif

    logic              is_ld, is_st, is_mem, sx, misal;
    logic [1:0]        sz;
    logic [OFF_W-1:0]  raw_off, off;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] sdat;
    logic [DATA_W-1:0] shifted, ld_res;

    // Decode the incoming memop into direction, size and signedness
    always_comb begin
        is_ld = 1'b0;
        is_st = 1'b0;
        sz    = SZ_B;
        sx    = 1'b0;
        case (in_memop)
            4'd1: begin is_ld = 1'b1; sz = SZ_B; sx = 1'b1; end
            4'd2: begin is_ld = 1'b1; sz = SZ_B; end
            4'd3: begin is_ld = 1'b1; sz = SZ_H; sx = 1'b1; end
            4'd4: begin is_ld = 1'b1; sz = SZ_H; end
            4'd5: begin is_ld = 1'b1; sz = SZ_W; end
            4'd6: begin is_st = 1'b1; sz = SZ_B; end
            4'd7: begin is_st = 1'b1; sz = SZ_H; end
            4'd8: begin is_st = 1'b1; sz = SZ_W; end
            default: ;
        endcase
        is_mem = is_ld | is_st;
    end

    // Lane offset, byte enables and lane-replicated store data
    always_comb begin
        raw_off = in_maddr[OFF_W-1:0];
        off     = raw_off;
        if (sz == SZ_H) off[0] = 1'b0;
        if (sz == SZ_W) off[1:0] = 2'b00;
`ifdef MEM_ALIGN_CHECK_EN
        misal = is_mem & (((sz == SZ_H) & raw_off[0])
              | ((sz == SZ_W) & (|raw_off[1:0])));
`else
        misal = 1'b0;
`endif
        case (sz)
            SZ_B:    be = BE_W'(1) << off;
            SZ_H:    be = BE_W'(3) << off;
            default: be = BE_W'(15) << off;
        endcase
        case (sz)
            SZ_B:    sdat = {BE_W{in_sdata[7:0]}};
            SZ_H:    sdat = {NH{in_sdata[15:0]}};
            default: sdat = {NW{in_sdata[31:0]}};
        endcase
    end

    // Shift the addressed lane of the read data down and extend it
    always_comb begin
        shifted = dm_rdata >> {off_q, 3'b000};
        case (sz_q)
            SZ_B: begin
                ld_res      = {DATA_W{sx_q & shifted[7]}};
                ld_res[7:0] = shifted[7:0];
            end
            SZ_H: begin
                ld_res       = {DATA_W{sx_q & shifted[15]}};
                ld_res[15:0] = shifted[15:0];
            end
            default: begin
                ld_res       = '0;
                ld_res[31:0] = shifted[31:0];
            end
        endcase
    end

    // Next-state, capture and writeback logic
    always_comb begin
        state_d  = state_q;
        waddr_d  = waddr_q;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        hilo_d   = hilo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        ld_d     = ld_q;
        sz_d     = sz_q;
        sx_d     = sx_q;
        off_d    = off_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        sdat_d   = sdat_q;
        exc_d    = exc_q;
        ov_d     = 1'b0;
        owreg_d  = owreg_q;
        owaddr_d = owaddr_q;
        owdata_d = owdata_q;
        ohilo_d  = ohilo_q;
        ohi_d    = ohi_q;
        olo_d    = olo_q;
`ifdef MEM_ALIGN_CHECK_EN
        oexc_d   = oexc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid && !is_mem) begin
                    ov_d     = 1'b1;
                    owreg_d  = in_wreg;
                    owaddr_d = in_waddr;
                    owdata_d = in_wdata;
                    ohilo_d  = in_we_hilo;
                    ohi_d    = in_wdata_hi;
                    olo_d    = in_wdata_lo;
`ifdef MEM_ALIGN_CHECK_EN
                    oexc_d   = 1'b0;
`endif
                end else if (in_valid) begin
                    waddr_d = in_waddr;
                    wreg_d  = in_wreg;
                    wdata_d = in_wdata;
                    hilo_d  = in_we_hilo;
                    hi_d    = in_wdata_hi;
                    lo_d    = in_wdata_lo;
                    ld_d    = is_ld;
                    sz_d    = sz;
                    sx_d    = sx;
                    off_d   = off;
                    we_d    = is_st;
                    addr_d  = {in_maddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    be_d    = be;
                    sdat_d  = sdat;
                    exc_d   = misal;
                    state_d = misal ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (dm_ack) begin
                    if (ld_q) wdata_d = ld_res;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ov_d     = 1'b1;
                owreg_d  = wreg_q & ~exc_q;
                owaddr_d = waddr_q;
                owdata_d = wdata_q;
                ohilo_d  = hilo_q;
                ohi_d    = hi_q;
                olo_d    = lo_q;
`ifdef MEM_ALIGN_CHECK_EN
                oexc_d   = exc_q;
`endif
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, captured transaction and writeback registers
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= S_IDLE;
            waddr_q  <= '0;
            wreg_q   <= 1'b0;
            wdata_q  <= '0;
            hilo_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            ld_q     <= 1'b0;
            sz_q     <= SZ_B;
            sx_q     <= 1'b0;
            off_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            sdat_q   <= '0;
            exc_q    <= 1'b0;
            ov_q     <= 1'b0;
            owreg_q  <= 1'b0;
            owaddr_q <= '0;
            owdata_q <= '0;
            ohilo_q  <= 1'b0;
            ohi_q    <= '0;
            olo_q    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            oexc_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            waddr_q  <= waddr_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            hilo_q   <= hilo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            ld_q     <= ld_d;
            sz_q     <= sz_d;
            sx_q     <= sx_d;
            off_q    <= off_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            sdat_q   <= sdat_d;
            exc_q    <= exc_d;
            ov_q     <= ov_d;
            owreg_q  <= owreg_d;
            owaddr_q <= owaddr_d;
            owdata_q <= owdata_d;
            ohilo_q  <= ohilo_d;
            ohi_q    <= ohi_d;
            olo_q    <= olo_d;
`ifdef MEM_ALIGN_CHECK_EN
            oexc_q   <= oexc_d;
`endif
        end
    end

    // Handshake is forced low while reset is held
    assign in_ready  = rst_ & (state_q == S_IDLE);
    assign stall_req = rst_ & (state_q != S_IDLE);

    assign dm_req   = (state_q == S_REQ);
    assign dm_we    = we_q;
    assign dm_addr  = addr_q;
    assign dm_be    = be_q;
    assign dm_wdata = sdat_q;

    assign out_valid    = ov_q;
    assign out_wreg     = owreg_q;
    assign out_waddr    = owaddr_q;
    assign out_wdata    = owdata_q;
    assign out_we_hilo  = ohilo_q;
    assign out_wdata_hi = ohi_q;
    assign out_wdata_lo = olo_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign out_align_exc = oexc_q;
`endif

endmodule
